port_bus_pipe: RTL and testbench
================================

PORT_BUS_PIPE -- requirements
Module: port_bus_pipe

Interface
REQ-001 The block SHALL have parameter IN_W, default 8: width of in_bus; a multiple of SLICE_W, at least 2*SLICE_W.
REQ-002 The block SHALL have parameter SLICE_W, default 4: width of one selectable slice and of out_bus.
REQ-003 The block SHALL have parameter DEPTH, default 2: number of pipeline stages, range 1..8.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_bus, input, IN_W bits: source data bus.
REQ-007 The block SHALL have port in_sel, input, SW = clog2(IN_W/SLICE_W) bits: slice index; slice k is in_bus[k*SLICE_W +: SLICE_W].
REQ-008 The block SHALL have port in_single, input, 1 bit: single-bit companion data.
REQ-009 The block SHALL have port in_inv, input, 1 bit: when 1, slice data is inverted at capture.
REQ-010 The block SHALL have port in_valid, input, 1 bit; and port in_ready, output, 1 bit: upstream handshake.
REQ-011 The block SHALL have port out_bus, output, SLICE_W bits; and port out_single, output, 1 bit: delivered beat.
REQ-012 The block SHALL have port out_valid, output, 1 bit; and port out_ready, input, 1 bit: downstream handshake.
REQ-013 The block SHALL have port beat_cnt, output, 8 bits: count of beats delivered, saturating.
REQ-014 The block SHALL have port sel_err, output, 1 bit: sticky flag for an out-of-range in_sel.

Function
REQ-015 A beat SHALL transfer on a port when valid and ready are both 1 at a rising clk edge.
REQ-016 At stage 0 capture, data SHALL be the selected slice, XORed with {SLICE_W{in_inv}}, and single SHALL be ~in_single.
REQ-017 Each stage i SHALL hold one beat (data, single) plus a valid bit.
REQ-018 Stage i SHALL accept a beat when it is empty or when its current beat moves to stage i+1 (or out, for stage DEPTH-1) in the same cycle.
REQ-019 in_ready SHALL equal stage 0's accept condition (combinational from stage valids and out_ready); full throughput is 1 beat/clk.
REQ-020 Latency SHALL be exactly DEPTH cycles from an input transfer to out_valid when no stalls occur.
REQ-021 out_bus, out_single and out_valid SHALL be driven directly from stage DEPTH-1 registers, with no combinational path from inputs.
REQ-022 Under out_ready=0 with all stages full, no beat SHALL be lost or duplicated, and in_ready SHALL be 0.
REQ-023 Order SHALL be preserved.
REQ-024 beat_cnt SHALL increment on each output transfer and hold at 255.
REQ-025 If in_sel >= IN_W/SLICE_W on an input transfer, the beat SHALL be captured with data 0, and sel_err SHALL set and remain 1 until reset.
REQ-026 Simultaneous input and output transfers SHALL both take effect in the same cycle.
REQ-027 in_bus, in_sel, in_single and in_inv SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst_n=0, all stage valids SHALL be 0, all stage data 0, out_valid=0, out_bus=0, out_single=0, beat_cnt=0, and sel_err=0.
REQ-029 Reset assertion mid-transfer SHALL discard all in-flight beats immediately, asynchronously.
REQ-030 in_ready SHALL be 1 in the first cycle after deassertion.

Structure
REQ-031 Package port_bus_pkg SHALL hold the parameter defaults, the CNT_W=8 and CNT_MAX constants, and the stage payload struct (data, single).
REQ-032 A single sub-module, port_bus_stage, SHALL implement one register stage (valid, payload, accept logic), instantiated DEPTH times by a generate loop.

Verification
REQ-033 Verification SHALL cover: reset, then in_bus=8'hA5, in_sel=1, in_inv=0, in_single=0, one beat, out_ready=1 -> out_bus=4'hA and out_single=1 exactly 2 clk later, beat_cnt=1.
REQ-034 Verification SHALL cover: in_bus=8'hA5, in_sel=0, in_inv=1 -> out_bus=4'hA.
REQ-035 Verification SHALL cover: out_ready=0 with 3 beats offered -> 2 accepted, in_ready=0 on the third; out_ready then set to 1 -> beats emerge in order, with no loss.
REQ-036 Verification SHALL cover: IN_W=16, SLICE_W=4, in_sel=3, in_bus=16'h1234 -> out_bus=4'h1; IN_W=12, in_sel=3 -> out_bus=0 and sel_err=1, persisting until reset.
REQ-037 Verification SHALL cover: 300 back-to-back beats with out_ready=1 -> one beat per clk after fill, and beat_cnt=255.
REQ-038 Verification SHALL cover: rst_n pulsed low with the pipeline full -> out_valid=0 immediately, and no stale beat appears after release.

Source files
------------

// File: rtl/port_bus_pkg.sv
// ==== port_bus_pkg : shared defaults, counter limits and stage payload (rev 1.0) ====
`default_nettype none

package port_bus_pkg;

  localparam int IN_W_DEF    = 8;
  localparam int SLICE_W_DEF = 4;
  localparam int DEPTH_DEF   = 2;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [SLICE_W_DEF-1:0] data;
    logic                   single;
  } payload_t;

endpackage

`default_nettype wire

// File: rtl/port_bus_stage.sv
// ==== port_bus_stage : one valid/ready register slice of the pipe (rev 1.0) ====
`default_nettype none

module port_bus_stage
  import port_bus_pkg::*;
#(
  parameter type T = payload_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  T     in_data,
  output logic in_ready,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready
);

  // Accept when empty, or when the held beat leaves in this same cycle.
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/port_bus_pipe.sv
// ==== port_bus_pipe : slice-select capture feeding a DEPTH-stage valid/ready pipe (rev 1.0) ====
`default_nettype none

module port_bus_pipe
  import port_bus_pkg::*;
#(
  parameter  int IN_W    = IN_W_DEF,
  parameter  int SLICE_W = SLICE_W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  localparam int NSLICE  = IN_W / SLICE_W,
  localparam int SW      = $clog2(NSLICE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    in_bus,
  input  logic [SW-1:0]      in_sel,
  input  logic               in_single,
  input  logic               in_inv,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SLICE_W-1:0] out_bus,
  output logic               out_single,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   beat_cnt,
  output logic               sel_err
);

  typedef struct packed {
    logic [SLICE_W-1:0] data;
    logic               single;
  } stage_t;

  logic [SLICE_W-1:0] w_slices [NSLICE];
  logic [SLICE_W-1:0] w_sel_data;
  logic               w_sel_bad;
  stage_t             w_cap;

  // Index 0 is the upstream port, index DEPTH the downstream port.
  logic   w_vld [DEPTH+1];
  logic   w_rdy [DEPTH+1];
  stage_t w_pay [DEPTH+1];

  generate
    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
      assign w_slices[k] = in_bus[k*SLICE_W +: SLICE_W];
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    w_sel_bad  = 1'b1;
    for (int k = 0; k < NSLICE; k++) begin
      if (in_sel == SW'(k)) begin
        w_sel_data = w_slices[k];
        w_sel_bad  = 1'b0;
      end
    end
  end

  // Out-of-range selects are captured as zero, not as inverted zero.
  always_comb begin
    w_cap.data   = w_sel_bad ? '0 : (w_sel_data ^ {SLICE_W{in_inv}});
    w_cap.single = ~in_single;
  end

  assign w_vld[0]     = in_valid;
  assign w_pay[0]     = w_cap;
  assign in_ready     = w_rdy[0];
  assign w_rdy[DEPTH] = out_ready;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      port_bus_stage #(
        .T (stage_t)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_vld[i]),
        .in_data   (w_pay[i]),
        .in_ready  (w_rdy[i]),
        .out_valid (w_vld[i+1]),
        .out_data  (w_pay[i+1]),
        .out_ready (w_rdy[i+1])
      );
    end
  endgenerate

  assign out_valid  = w_vld[DEPTH];
  assign out_bus    = w_pay[DEPTH].data;
  assign out_single = w_pay[DEPTH].single;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (out_valid && out_ready && (beat_cnt != CNT_MAX)) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (in_valid && in_ready && w_sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_port_bus_pipe.sv
// ==== tb_port_bus_pipe : directed vectors plus queue-based model for port_bus_pipe (rev 1.0) ====
`default_nettype none

module tb_port_bus_pipe;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_bus = '0;
  logic       in_sel = 1'b0;
  logic       in_single = 1'b0, in_inv = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       in_ready, out_single, out_valid, sel_err;
  logic [3:0] out_bus;
  logic [7:0] beat_cnt;

  logic [15:0] b16 = '0;
  logic [1:0]  s16 = '0;
  logic        v16 = 1'b0;
  logic        r16, os16, ov16, e16;
  logic [3:0]  ob16;
  logic [7:0]  c16;

  logic [11:0] b12 = '0;
  logic [1:0]  s12 = '0;
  logic        v12 = 1'b0;
  logic        r12, os12, ov12, e12;
  logic [3:0]  ob12;
  logic [7:0]  c12;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  port_bus_pipe #(.IN_W(8), .SLICE_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_sel(in_sel), .in_single(in_single),
    .in_inv(in_inv), .in_valid(in_valid), .in_ready(in_ready), .out_bus(out_bus),
    .out_single(out_single), .out_valid(out_valid), .out_ready(out_ready),
    .beat_cnt(beat_cnt), .sel_err(sel_err));

  port_bus_pipe #(.IN_W(16), .SLICE_W(4), .DEPTH(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_bus(b16), .in_sel(s16), .in_single(1'b0),
    .in_inv(1'b0), .in_valid(v16), .in_ready(r16), .out_bus(ob16),
    .out_single(os16), .out_valid(ov16), .out_ready(1'b1),
    .beat_cnt(c16), .sel_err(e16));

  port_bus_pipe #(.IN_W(12), .SLICE_W(4), .DEPTH(2)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_bus(b12), .in_sel(s12), .in_single(1'b0),
    .in_inv(1'b0), .in_valid(v12), .in_ready(r12), .out_bus(ob12),
    .out_single(os12), .out_valid(ov12), .out_ready(1'b1),
    .beat_cnt(c12), .sel_err(e12));

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of in-flight beats with positions
  typedef struct {
    int         pos;
    logic [3:0] data;
    logic       single;
  } mbeat_t;

  mbeat_t q[$];
  int     m_cnt = 0;

  function automatic logic [3:0] exp_slice(input logic [7:0] bus, input int sel, input logic inv);
    logic [7:0] sh;
    if (sel >= 2) return 4'h0;
    sh = bus >> (sel * 4);
    return sh[3:0] ^ {4{inv}};
  endfunction

  function automatic bit m_out_valid();
    return (q.size() > 0) && (q[0].pos == DEPTH - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin : upd
      bit     ofire, ifire;
      int     lim;
      mbeat_t nb;
      ofire = m_out_valid() && out_ready;
      ifire = in_valid && ((q.size() < DEPTH) || out_ready);
      if (ofire) begin
        void'(q.pop_front());
        if (m_cnt < 255) m_cnt++;
      end
      lim = DEPTH - 1;
      foreach (q[i]) begin
        q[i].pos = (q[i].pos + 1 < lim) ? q[i].pos + 1 : lim;
        lim = q[i].pos - 1;
      end
      if (ifire) begin
        nb.pos    = 0;
        nb.data   = exp_slice(in_bus, int'(in_sel), in_inv);
        nb.single = ~in_single;
        q.push_back(nb);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_in_ready", in_ready, ((q.size() < DEPTH) || out_ready) ? 16'd1 : 16'd0);
      check("m_out_valid", out_valid, m_out_valid() ? 16'd1 : 16'd0);
      if (m_out_valid()) begin
        check("m_out_bus", out_bus, q[0].data);
        check("m_out_single", out_single, q[0].single);
      end
      check("m_beat_cnt", beat_cnt, m_cnt);
      check("m_sel_err", sel_err, 0);
    end
  end

  // ---------------- directed stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ov_cnt;
    tick();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bus", out_bus, 0);
    check("rst_out_single", out_single, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_sel_err", sel_err, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // single beat, slice 1 of A5, no invert
    out_ready = 1'b1;
    in_bus = 8'hA5; in_sel = 1'b1; in_inv = 1'b0; in_single = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_bus = 8'hFF;
    #1 check("lat1_out_valid", out_valid, 0);
    tick();
    check("lat2_out_valid", out_valid, 1);
    check("lat2_out_bus", out_bus, 4'hA);
    check("lat2_out_single", out_single, 1);
    tick();
    check("cnt_after_1", beat_cnt, 1);

    // slice 0 inverted
    in_bus = 8'hA5; in_sel = 1'b0; in_inv = 1'b1; in_single = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_inv = 1'b0;
    tick();
    check("inv_out_bus", out_bus, 4'hA);
    check("inv_out_single", out_single, 0);
    tick();
    check("cnt_after_2", beat_cnt, 2);

    // backpressure: three beats offered into a stalled pipe
    out_ready = 1'b0; in_sel = 1'b0; in_valid = 1'b1;
    in_bus = 8'h01;
    tick();
    in_bus = 8'h02;
    tick();
    in_bus = 8'h03;
    #1 check("stall_in_ready", in_ready, 0);
    tick();
    tick();
    check("stall_in_ready_hold", in_ready, 0);
    check("stall_head", out_bus, 4'h1);
    out_ready = 1'b1;
    #1 check("unstall_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("order_2", out_bus, 4'h2);
    tick();
    check("order_3", out_bus, 4'h3);
    tick();
    check("drained_valid", out_valid, 0);
    check("cnt_after_5", beat_cnt, 5);

    // wider and non-power-of-two source buses
    b16 = 16'h1234; s16 = 2'd3; v16 = 1'b1;
    b12 = 12'h123;  s12 = 2'd3; v12 = 1'b1;
    tick();
    v16 = 1'b0; v12 = 1'b0;
    check("w12_sel_err_set", e12, 1);
    tick();
    check("w16_out_valid", ov16, 1);
    check("w16_out_bus", ob16, 4'h1);
    check("w12_out_valid", ov12, 1);
    check("w12_out_bus", ob12, 4'h0);
    check("w16_sel_err", e16, 0);
    b12 = 12'hABC; s12 = 2'd2; v12 = 1'b1;
    tick();
    v12 = 1'b0;
    tick();
    check("w12_in_range_bus", ob12, 4'hA);
    check("w12_sel_err_sticky", e12, 1);

    // randomized mix of valid and ready patterns
    for (int i = 0; i < 150; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_bus    = 8'($urandom);
      in_sel    = 1'($urandom_range(0, 1));
      in_inv    = 1'($urandom_range(0, 1));
      in_single = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    // 300 back-to-back beats
    ov_cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_bus = 8'(i); in_sel = 1'(i % 2); in_inv = 1'((i / 3) % 2); in_single = 1'(i % 5 == 0);
      tick();
      if (i >= 1 && out_valid) ov_cnt++;
    end
    in_valid = 1'b0;
    check("stream_out_valid_cycles", ov_cnt, 299);
    tick(); tick(); tick();
    check("cnt_saturated", beat_cnt, 255);

    // reset with a full pipe
    out_ready = 1'b0; in_valid = 1'b1; in_bus = 8'h77;
    tick(); tick();
    in_valid = 1'b0;
    check("full_before_rst", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_beat_cnt", beat_cnt, 0);
    check("async_rst_w12_err", e12, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_beat", out_valid, 0);
    end
    check("w12_err_after_rst", e12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
